// File: rtl/counter_bank_drain_pkg.sv
// Shared types and constants for the per-flow counter bank read-and-clear drain.
// The optional write-back of zero is controlled by the COUNTER_CLEAR_EN macro.
package counter_bank_drain_pkg;

  localparam int unsigned ID_WIDTH       = 12;
  localparam int unsigned COUNTER_WIDTH  = 20;
  localparam int unsigned RAM_RD_LATENCY = 2;
  localparam int unsigned LAT_W          = 2;

  localparam logic BANK1 = 1'b0;
  localparam logic BANK2 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CAP,
    S_OUT,
    S_CLR,
    S_NEXT
  } state_t;

  // Drained record as seen by the downstream readout.
  typedef struct packed {
    logic                     bank;
    logic [ID_WIDTH-1:0]      id;
    logic [COUNTER_WIDTH-1:0] counter;
  } drain_rec_t;

endpackage

// File: rtl/counter_bank_drain_if.sv
// Valid/ready record stream carrying one drained counter (bank, id, value).
interface counter_bank_drain_if
  import counter_bank_drain_pkg::*;
#(
  parameter int unsigned C_ID_WIDTH      = ID_WIDTH,
  parameter int unsigned C_COUNTER_WIDTH = COUNTER_WIDTH
);

  logic                       out_valid;
  logic                       in_ready;
  logic                       out_bank;
  logic [C_ID_WIDTH-1:0]      out_id;
  logic [C_COUNTER_WIDTH-1:0] out_counter;

  modport master (
    output out_valid, out_bank, out_id, out_counter,
    input  in_ready
  );

  modport slave (
    input  out_valid, out_bank, out_id, out_counter,
    output in_ready
  );

endinterface

// File: rtl/counter_bank_ptr.sv
// One bank's sweep pointer with wrap detection and a drained flag that is
// re-armed whenever the bank's read window is seen closed.
module counter_bank_ptr #(
  parameter int unsigned C_ID_WIDTH = 12,
  parameter int unsigned C_NUM_IDS  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  window,
  output logic [C_ID_WIDTH-1:0] ptr,
  output logic                  drained,
  output logic                  last_c
);

  localparam logic [C_ID_WIDTH-1:0] LAST_ID = C_ID_WIDTH'(C_NUM_IDS - 1);

  assign last_c = (ptr == LAST_ID);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      drained <= 1'b0;
    end else begin
      if (advance) begin
        ptr <= last_c ? '0 : ptr + C_ID_WIDTH'(1);
      end
      // A closed window wins so a completed bank re-arms for its next window.
      if (!window) begin
        drained <= 1'b0;
      end else if (advance && last_c) begin
        drained <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_bank_drain.sv
// Read-and-clear controller for two ping-pong counter banks via RAM port B.
// Macro COUNTER_CLEAR_EN enables the zero write-back; otherwise the sweep is read-only.
module counter_bank_drain
  import counter_bank_drain_pkg::*;
#(
  parameter int unsigned C_ID_WIDTH      = ID_WIDTH,
  parameter int unsigned C_COUNTER_WIDTH = COUNTER_WIDTH,
  parameter int unsigned C_NUM_IDS       = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_enable,
  input  logic                       in_ready_read_1,
  input  logic                       in_ready_read_2,
  output logic                       out_ram_en1b,
  output logic                       out_ram_regce1b,
  output logic                       out_ram_we1b,
  output logic [C_ID_WIDTH-1:0]      out_ram_addr1b,
  output logic [C_COUNTER_WIDTH-1:0] out_ram_din1b,
  input  logic [C_COUNTER_WIDTH-1:0] in_ram_dout1b,
  output logic                       out_ram_en2b,
  output logic                       out_ram_regce2b,
  output logic                       out_ram_we2b,
  output logic [C_ID_WIDTH-1:0]      out_ram_addr2b,
  output logic [C_COUNTER_WIDTH-1:0] out_ram_din2b,
  input  logic [C_COUNTER_WIDTH-1:0] in_ram_dout2b,
  counter_bank_drain_if.master       drain,
  output logic                       out_done,
  output logic                       out_busy
);

  state_t                     state_q, state_n;
  logic                       sel_q, sel_n;
  logic [C_ID_WIDTH-1:0]      addr_q, addr_n;
  logic [LAT_W-1:0]           lat_q, lat_n;
  logic                       en_q, en_n;
  logic                       en1_q, en2_q;
  logic [C_ID_WIDTH-1:0]      addr1_q, addr2_q;
  logic                       valid_q, valid_n;
  logic                       bank_q, bank_n;
  logic [C_ID_WIDTH-1:0]      id_q, id_n;
  logic [C_COUNTER_WIDTH-1:0] cnt_q, cnt_n;
  logic                       done_q, done_n;
  logic                       busy_q;
  logic                       adv_c;
`ifdef COUNTER_CLEAR_EN
  logic                       we_n;
  logic                       we1_q, we2_q;
`endif

  logic [C_ID_WIDTH-1:0]      ptr1, ptr2;
  logic                       drained1, drained2;
  logic                       last1_c, last2_c;

  logic                       adv1_c, adv2_c;
  logic [C_ID_WIDTH-1:0]      cur_ptr_c;
  logic                       cur_last_c, cur_win_c, cur_drained_c;
  logic [C_COUNTER_WIDTH-1:0] cur_dout_c;

  assign adv1_c        = adv_c && (sel_q == BANK1);
  assign adv2_c        = adv_c && (sel_q == BANK2);
  assign cur_ptr_c     = (sel_q == BANK2) ? ptr2 : ptr1;
  assign cur_last_c    = (sel_q == BANK2) ? last2_c : last1_c;
  assign cur_win_c     = (sel_q == BANK2) ? in_ready_read_2 : in_ready_read_1;
  assign cur_drained_c = (sel_q == BANK2) ? drained2 : drained1;
  assign cur_dout_c    = (sel_q == BANK2) ? in_ram_dout2b : in_ram_dout1b;

  counter_bank_ptr #(
    .C_ID_WIDTH (C_ID_WIDTH),
    .C_NUM_IDS  (C_NUM_IDS)
  ) u_ptr1 (
    .clk     (clk),
    .rst     (rst),
    .advance (adv1_c),
    .window  (in_ready_read_1),
    .ptr     (ptr1),
    .drained (drained1),
    .last_c  (last1_c)
  );

  counter_bank_ptr #(
    .C_ID_WIDTH (C_ID_WIDTH),
    .C_NUM_IDS  (C_NUM_IDS)
  ) u_ptr2 (
    .clk     (clk),
    .rst     (rst),
    .advance (adv2_c),
    .window  (in_ready_read_2),
    .ptr     (ptr2),
    .drained (drained2),
    .last_c  (last2_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    addr_n  = addr_q;
    lat_n   = lat_q;
    en_n    = en_q;
    valid_n = valid_q;
    bank_n  = bank_q;
    id_n    = id_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
    adv_c   = 1'b0;
`ifdef COUNTER_CLEAR_EN
    we_n    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        en_n = 1'b0;
        if (in_enable && in_ready_read_1 && !drained1) begin
          sel_n   = BANK1;
          addr_n  = ptr1;
          en_n    = 1'b1;
          state_n = S_RD;
        end else if (in_enable && in_ready_read_2 && !drained2) begin
          sel_n   = BANK2;
          addr_n  = ptr2;
          en_n    = 1'b1;
          state_n = S_RD;
        end
      end
      S_RD: begin
        lat_n   = LAT_W'(RAM_RD_LATENCY - 2);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_n = S_CAP;
        end else begin
          lat_n = lat_q - LAT_W'(1);
        end
      end
      S_CAP: begin
        valid_n = 1'b1;
        bank_n  = sel_q;
        id_n    = cur_ptr_c;
        cnt_n   = cur_dout_c;
        state_n = S_OUT;
      end
      S_OUT: begin
        // The record is held until accepted, regardless of the window.
        if (drain.in_ready) begin
          valid_n = 1'b0;
`ifdef COUNTER_CLEAR_EN
          we_n    = 1'b1;
          state_n = S_CLR;
`else
          en_n    = 1'b0;
          state_n = S_NEXT;
`endif
        end
      end
      S_CLR: begin
        en_n    = 1'b0;
        state_n = S_NEXT;
      end
      S_NEXT: begin
        adv_c  = 1'b1;
        done_n = cur_last_c;
        if (cur_win_c && in_enable && !cur_last_c && !cur_drained_c) begin
          en_n    = 1'b1;
          addr_n  = cur_ptr_c + C_ID_WIDTH'(1);
          state_n = S_RD;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Port-B controls are registered per bank so the unselected bank stays quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q   <= BANK1;
      addr_q  <= '0;
      lat_q   <= '0;
      en_q    <= 1'b0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      valid_q <= 1'b0;
      bank_q  <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sel_q   <= sel_n;
      addr_q  <= addr_n;
      lat_q   <= lat_n;
      en_q    <= en_n;
      en1_q   <= en_n && (sel_n == BANK1);
      en2_q   <= en_n && (sel_n == BANK2);
      if (en_n && (sel_n == BANK1)) begin
        addr1_q <= addr_n;
      end
      if (en_n && (sel_n == BANK2)) begin
        addr2_q <= addr_n;
      end
      valid_q <= valid_n;
      bank_q  <= bank_n;
      id_q    <= id_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
      busy_q  <= (state_n != S_IDLE);
    end
  end

`ifdef COUNTER_CLEAR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we1_q <= 1'b0;
      we2_q <= 1'b0;
    end else begin
      we1_q <= we_n && (sel_n == BANK1);
      we2_q <= we_n && (sel_n == BANK2);
    end
  end

  assign out_ram_we1b = we1_q;
  assign out_ram_we2b = we2_q;
`else
  assign out_ram_we1b = 1'b0;
  assign out_ram_we2b = 1'b0;
`endif

  assign out_ram_en1b    = en1_q;
  assign out_ram_regce1b = en1_q;
  assign out_ram_addr1b  = addr1_q;
  assign out_ram_din1b   = '0;
  assign out_ram_en2b    = en2_q;
  assign out_ram_regce2b = en2_q;
  assign out_ram_addr2b  = addr2_q;
  assign out_ram_din2b   = '0;

  assign drain.out_valid   = valid_q;
  assign drain.out_bank    = bank_q;
  assign drain.out_id      = id_q;
  assign drain.out_counter = cnt_q;
  assign out_done          = done_q;
  assign out_busy          = busy_q;

endmodule

// File: tb/tb_counter_bank_drain.sv
// Directed bench for counter_bank_drain with two 2-cycle-latency RAM models.
// Expectations follow the COUNTER_CLEAR_EN setting of the build.
module tb_counter_bank_drain;
  import counter_bank_drain_pkg::*;

  localparam int unsigned IDW  = 12;
  localparam int unsigned CW   = 20;
  localparam int unsigned NIDS = 8;
`ifdef COUNTER_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    logic        bank;
    int unsigned id;
    int unsigned preload;
    drain_rec_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_enable, rr1, rr2, load_mem;
  logic en1b, regce1b, we1b, en2b, regce2b, we2b, out_done, out_busy;
  logic [IDW-1:0] addr1b, addr2b;
  logic [CW-1:0]  din1b, din2b, dout1, dout2, stage1, stage2;
  logic [CW-1:0]  mem1 [NIDS];
  logic [CW-1:0]  mem2 [NIDS];

  vec_t       tbl [16];
  drain_rec_t got_q [$];
  int done_cnt = 0, we1_cnt = 0, b2_cnt = 0, both_cnt = 0, bad_addr = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  counter_bank_drain_if #(.C_ID_WIDTH(IDW), .C_COUNTER_WIDTH(CW)) dif ();

  counter_bank_drain #(
    .C_ID_WIDTH(IDW), .C_COUNTER_WIDTH(CW), .C_NUM_IDS(NIDS)
  ) dut (
    .clk(clk), .rst(rst), .in_enable(in_enable),
    .in_ready_read_1(rr1), .in_ready_read_2(rr2),
    .out_ram_en1b(en1b), .out_ram_regce1b(regce1b), .out_ram_we1b(we1b),
    .out_ram_addr1b(addr1b), .out_ram_din1b(din1b), .in_ram_dout1b(dout1),
    .out_ram_en2b(en2b), .out_ram_regce2b(regce2b), .out_ram_we2b(we2b),
    .out_ram_addr2b(addr2b), .out_ram_din2b(din2b), .in_ram_dout2b(dout2),
    .drain(dif), .out_done(out_done), .out_busy(out_busy)
  );

  // Port-B RAM models: read-first, registered read plus output register.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < NIDS; i++) begin
        mem1[i] <= CW'(tbl[i].preload);
        mem2[i] <= CW'(tbl[8+i].preload);
      end
    end else begin
      if (en1b) begin
        if (we1b) mem1[addr1b[2:0]] <= din1b;
        stage1 <= mem1[addr1b[2:0]];
      end
      if (en2b) begin
        if (we2b) mem2[addr2b[2:0]] <= din2b;
        stage2 <= mem2[addr2b[2:0]];
      end
    end
    if (regce1b) dout1 <= stage1;
    if (regce2b) dout2 <= stage2;
  end

  always @(negedge clk) begin
    if (dif.out_valid && dif.in_ready)
      got_q.push_back('{bank: dif.out_bank, id: dif.out_id, counter: dif.out_counter});
    if (out_done) done_cnt <= done_cnt + 1;
    if (we1b) we1_cnt <= we1_cnt + 1;
    if (en2b || regce2b || we2b) b2_cnt <= b2_cnt + 1;
    if ((en1b || we1b) && (en2b || we2b)) both_cnt <= both_cnt + 1;
    if ((en1b && addr1b >= IDW'(NIDS)) || (en2b && addr2b >= IDW'(NIDS))) bad_addr <= bad_addr + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load();
    load_mem = 1'b1;
    tick(1);
    load_mem = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic take_item(input string tag);
    bit ok;
    wait_valid(ok);
    if (!ok) chk({tag, " valid timeout"}, 64'(0), 64'(1));
    @(posedge clk); #1 dif.in_ready = 1'b1;
    @(posedge clk); #1 dif.in_ready = 1'b0;
  endtask

  task automatic cmp_stream(input string tag, input int base, input int first, input int n);
    drain_rec_t r;
    for (int i = 0; i < n; i++) begin
      r = (base + i < got_q.size()) ? got_q[base+i] : '1;
      chk($sformatf("%s rec%0d", tag, i), 64'(r), 64'(tbl[first+i].exp));
    end
  endtask

  task automatic chk_mem(input string tag, input bit bank2, input bit cleared);
    int bad = 0;
    logic [CW-1:0] act, exp;
    for (int i = 0; i < NIDS; i++) begin
      exp = cleared ? '0 : CW'(tbl[(bank2 ? 8 : 0) + i].preload);
      act = bank2 ? mem2[i] : mem1[i];
      if (act !== exp) bad++;
    end
    chk(tag, 64'(bad), 64'(0));
  endtask

  function automatic logic [63:0] idle_vec();
    return 64'({dif.out_valid, out_busy, out_done, en1b, regce1b, we1b, en2b, regce2b, we2b,
                dif.out_bank, dif.out_id, dif.out_counter});
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, d0, w0, b0, x0, unstable;
    bit ok, found;
    logic [IDW-1:0] snap_id;
    logic [CW-1:0]  snap_cnt;

    // Expected drain order: bank1 ids 0..7 (3*id), then bank2 ids 0..7 (100+id).
    for (int i = 0; i < 16; i++) begin
      tbl[i].bank    = (i >= 8);
      tbl[i].id      = i % 8;
      tbl[i].preload = tbl[i].bank ? 100 + tbl[i].id : 3 * tbl[i].id;
      tbl[i].exp     = '{bank: tbl[i].bank, id: IDW'(tbl[i].id), counter: CW'(tbl[i].preload)};
    end

    in_enable = 1'b0; rr1 = 1'b0; rr2 = 1'b0; load_mem = 1'b0; dif.in_ready = 1'b0;
    #1 rst = 1'b0;
    tick(3);
    chk("reset outputs", idle_vec(), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    load();

    // Enable low: an open window must not start a sweep.
    rr1 = 1'b1;
    base = got_q.size();
    tick(10);
    chk("enable low busy", 64'(out_busy), 64'(0));
    chk("enable low en1b", 64'(en1b), 64'(0));
    chk("enable low records", 64'(got_q.size() - base), 64'(0));
    rr1 = 1'b0;
    tick(2);

    // A: full bank1 sweep with in_ready held high.
    base = got_q.size(); d0 = done_cnt; w0 = we1_cnt; b0 = b2_cnt;
    in_enable = 1'b1; dif.in_ready = 1'b1; rr1 = 1'b1;
    tick(100);
    rr1 = 1'b0;
    tick(2);
    chk("A count", 64'(got_q.size() - base), 64'(8));
    cmp_stream("A", base, 0, 8);
    chk("A done", 64'(done_cnt - d0), 64'(1));
    chk("A we1", 64'(we1_cnt - w0), CLR ? 64'(8) : 64'(0));
    chk("A bank2 quiet", 64'(b2_cnt - b0), 64'(0));
    chk("A busy", 64'(out_busy), 64'(0));
    chk_mem("A mem1", 1'b0, CLR);
    chk_mem("A mem2", 1'b1, 1'b0);

    // B: backpressure while id 2 is presented.
    load();
    base = got_q.size(); d0 = done_cnt;
    dif.in_ready = 1'b0; rr1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        wait_valid(ok);
        chk("B id2 valid", 64'(ok), 64'(1));
        snap_id = dif.out_id; snap_cnt = dif.out_counter; unstable = 0;
        repeat (7) begin
          @(negedge clk);
          if (!dif.out_valid || dif.out_id !== snap_id || dif.out_counter !== snap_cnt || we1b) unstable++;
        end
        chk("B held id", 64'(snap_id), 64'(2));
        chk("B held counter", 64'(snap_cnt), 64'(6));
        chk("B hold stable", 64'(unstable), 64'(0));
        @(posedge clk); #1 dif.in_ready = 1'b1;
        @(posedge clk); #1 dif.in_ready = 1'b0;
      end else begin
        take_item("B");
      end
    end
    tick(10);
    rr1 = 1'b0;
    tick(2);
    chk("B count", 64'(got_q.size() - base), 64'(8));
    cmp_stream("B", base, 0, 8);
    chk("B done", 64'(done_cnt - d0), 64'(1));

    // C: window closes while id 4 is being read, then resumes.
    load();
    base = got_q.size(); d0 = done_cnt;
    dif.in_ready = 1'b1; rr1 = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (en1b && addr1b == IDW'(4)) found = 1'b1;
    end
    chk("C id4 read seen", 64'(found), 64'(1));
    @(posedge clk); #1 rr1 = 1'b0;
    tick(20);
    chk("C partial count", 64'(got_q.size() - base), 64'(5));
    chk("C partial done", 64'(done_cnt - d0), 64'(0));
    chk("C partial busy", 64'(out_busy), 64'(0));
    chk("C id4 mem", 64'(mem1[4]), CLR ? 64'(0) : 64'(12));
    chk("C id5 mem", 64'(mem1[5]), 64'(15));
    rr1 = 1'b1;
    tick(40);
    rr1 = 1'b0;
    tick(2);
    chk("C count", 64'(got_q.size() - base), 64'(8));
    cmp_stream("C", base, 0, 8);
    chk("C done", 64'(done_cnt - d0), 64'(1));

    // D: both windows open; bank1 first, bank2 afterwards, never together.
    load();
    base = got_q.size(); d0 = done_cnt; x0 = both_cnt;
    dif.in_ready = 1'b1; rr1 = 1'b1; rr2 = 1'b1;
    tick(150);
    rr1 = 1'b0; rr2 = 1'b0;
    tick(2);
    chk("D count", 64'(got_q.size() - base), 64'(16));
    cmp_stream("D", base, 0, 16);
    chk("D done", 64'(done_cnt - d0), 64'(2));
    chk("D no overlap", 64'(both_cnt - x0), 64'(0));
    chk_mem("D mem2", 1'b1, CLR);

    // E: asynchronous reset while id 2 waits in S_OUT.
    load();
    dif.in_ready = 1'b0; rr1 = 1'b1;
    take_item("E");
    take_item("E");
    wait_valid(ok);
    chk("E id2 presented", 64'(ok ? dif.out_id : IDW'(0)), 64'(2));
    @(posedge clk); #2 rst = 1'b0;
    #1 chk("E async reset", idle_vec(), 64'(0));
    dif.in_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    base = got_q.size(); d0 = done_cnt;
    tick(60);
    rr1 = 1'b0;
    tick(2);
    chk("E count", 64'(got_q.size() - base), 64'(8));
    for (int i = 0; i < 8; i++)
      chk($sformatf("E id%0d", i), 64'((base + i < got_q.size()) ? got_q[base+i].id : '1), 64'(i));
    chk("E id1 counter", 64'((base + 1 < got_q.size()) ? got_q[base+1].counter : '1), CLR ? 64'(0) : 64'(3));
    chk("E id2 counter", 64'((base + 2 < got_q.size()) ? got_q[base+2].counter : '1), 64'(6));
    chk("E done", 64'(done_cnt - d0), 64'(1));
    chk("address range", 64'(bad_addr), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
